mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle integer multiply/divide unit for the CPU datapath; results feed the Hi and Lo registers.
- Supports MULT, MULTU, DIV and DIVU at a parametrised operand width.
- Multiplication is iterative shift-add; division is restoring, one bit per cycle.
- The control FSM raises start and then waits for done. Hi/Lo are written only when the result is final.

Parameters:
WIDTH, 32, operand width in bits (at least 4); the product spans 2*WIDTH bits across hi:lo
CNT_W, $clog2(WIDTH+1), width of the iteration counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only while idle
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; hi/lo/div_zero valid in this cycle
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient
div_zero  output  1  divisor was zero on the last accepted division

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi, lo, busy, done, div_zero, counter and work registers all 0. Reset mid-operation abandons the operation with no hi/lo update.
- States:
  - IDLE: start=1 latches a, b and op, and clears div_zero; go to PREP. start=0 stays.
  - PREP: compute operand magnitudes. Signed ops record neg_q = sign(a)^sign(b) and neg_r = sign(a); unsigned ops set both flags to 0. Load counter with WIDTH.
    - Division with b==0 skips to DONE: div_zero=1, hi/lo unchanged.
    - Otherwise go to RUN.
  - RUN: one iteration per cycle, counter decrements. Leave for FIX when the counter reaches 0 after exactly WIDTH cycles.
    - MULT: if the accumulator LSB is 1, add the multiplicand to the upper half; then shift the {carry, acc} pair right by 1.
    - DIV: shift {rem, quo} left by 1, trial-subtract the divisor from rem; if there is no borrow, keep the result and set the quotient LSB.
  - FIX: apply sign correction (two's-complement negate) to the 2*WIDTH product if neg_q. For division, negate the quotient if neg_q and the remainder if neg_r. Register hi and lo at the end of this cycle; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Latency: with start sampled in cycle 0, done is high in cycle WIDTH+3. Division by zero gives done in cycle 2. busy is high from cycle 1 through the done cycle inclusive.
- start while busy: ignored, not queued. start in the same cycle as done: ignored. The earliest accepted restart is the cycle after done.
- Division semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed MIN / -1: lo=MIN, hi=0. This is the natural truncated result and raises no flag.
- Signed MIN * MIN: product 2^(2*WIDTH-2) is exact.
- div_zero stays held until the next accepted start.
- Operand inputs may change freely after the start cycle.
- hi/lo change only on the FIX to DONE edge.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum IDLE/PREP/RUN/FIX/DONE (3-bit encoding);
  - the localparam for the unsigned-op mask bit (op[0]).
- One sub-module is natural: mdu_step. It is combinational, parametrised by WIDTH, and computes one iteration given the mode bit, accumulator/remainder, quotient/multiplier and operand. The top level holds the FSM, counter, sign bookkeeping and the output registers.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFF b=0x00000002 -> done at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFE, div_zero=0.
- WIDTH=32, MULTU a=0xFFFFFFFF b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE. Also DIVU a=100 b=7 -> lo=14, hi=2.
- WIDTH=32, DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7 b=0 with prior hi=0x1234, lo=0x5678 -> done at cycle 2, div_zero=1, hi/lo unchanged. A following MULTU 3*4 -> div_zero cleared at accept, lo=12, hi=0.
- Start a MULT; pulse start with new operands at cycle 10; assert reset=0 at cycle 20 of a second operation -> first result unaffected by the cycle-10 pulse; after reset, busy=0, done=0, hi=lo=0, and no done pulse appears.
- WIDTH=8, MULT a=0x80 b=0x80 -> hi=0x40, lo=0x00, done at cycle 11. Also DIV a=0x85 (-123) b=0x0A -> lo=0xF4 (-12), hi=0xFD (-3).

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared opcode encodings, op-field bit positions and the FSM
//               state type for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation encodings presented on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // op[0] set means the operands are treated as unsigned
    localparam int OP_UNSIGNED_BIT = 0;
    // op[1] set selects division
    localparam int OP_DIV_BIT      = 1;

    // Control FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One iteration of shift-add multiply or restoring divide.
//               Multiply: {acc, quo} is the partial product / multiplier pair.
//               Divide:   acc is the remainder, quo the dividend/quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div_mode,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc_nxt,
    output logic [WIDTH-1:0] o_quo_nxt
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    // Compute both the multiply and divide step, select by mode
    always_comb begin
        // Multiply: conditional add keeps the carry so the right shift is exact
        w_sum    = i_quo[0] ? ({1'b0, i_acc} + {1'b0, i_operand}) : {1'b0, i_acc};
        // Divide: shifted remainder needs one extra bit before the trial subtract
        w_rem_sh = {i_acc, i_quo[WIDTH-1]};
        w_borrow = (w_rem_sh < {1'b0, i_operand});
        // When there is no borrow the true difference is below the divisor,
        // so the low WIDTH bits of the subtraction are the whole result
        w_diff   = w_rem_sh[WIDTH-1:0] - i_operand;

        if (i_div_mode) begin
            o_acc_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff;
            o_quo_nxt = {i_quo[WIDTH-2:0], ~w_borrow};
        end else begin
            o_acc_nxt = w_sum[WIDTH:1];
            o_quo_nxt = {w_sum[0], i_quo[WIDTH-1:1]};
        end
    end

endmodule : mdu_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed/unsigned multiply and divide feeding Hi/Lo.
//               Operands are reduced to magnitudes, iterated WIDTH times by
//               mdu_step, then sign-corrected before Hi/Lo are written.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_is_div;
    logic             w_unsigned;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    // Operand decode, magnitudes and final sign correction
    always_comb begin
        w_is_div   = r_op[OP_DIV_BIT];
        w_unsigned = r_op[OP_UNSIGNED_BIT];
        w_a_neg    = ~w_unsigned & r_a[WIDTH-1];
        w_b_neg    = ~w_unsigned & r_b[WIDTH-1];
        // The most negative value negates to itself, which is its correct
        // unsigned magnitude, so no extra bit is needed
        w_a_mag    = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_b_mag    = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_b_zero   = (r_b == '0);

        w_prod     = {r_acc, r_quo};
        w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
        if (w_is_div) begin
            w_hi_fix = r_neg_r ? (~r_acc + 1'b1) : r_acc;
            w_lo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        end else begin
            w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_fix = w_prod_fix[WIDTH-1:0];
        end
    end

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div_mode (w_is_div),
        .i_acc      (r_acc),
        .i_quo      (r_quo),
        .i_operand  (r_opnd),
        .o_acc_nxt  (w_acc_nxt),
        .o_quo_nxt  (w_quo_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; division by zero bypasses the iteration entirely
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = PREP;
            PREP:    w_state_nxt = (w_is_div && w_b_zero) ? DONE : RUN;
            RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and Hi/Lo result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_quo      <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_a        <= a;
                        r_b        <= b;
                        r_div_zero <= 1'b0;
                    end
                end
                PREP: begin
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_cnt   <= CNT_W'(WIDTH);
                    r_acc   <= '0;
                    r_quo   <= w_is_div ? w_a_mag : w_b_mag;
                    r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                    if (w_is_div && w_b_zero) begin
                        r_div_zero <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit at WIDTH=32
//               and WIDTH=8, with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        s32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        s8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int n_cmp = 0;
    int n_err = 0;

    // Free-running clock
    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(s32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(s8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, then check latency, busy, div_zero and Hi/Lo
    task automatic run_chk(input string tag, input bit w8, input logic [1:0] o,
                           input logic [31:0] av, input logic [31:0] bv,
                           input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz);
        int lat;
        @(negedge clk);
        if (w8) begin s8 = 1'b1; op8 = o; a8 = av[7:0]; b8 = bv[7:0]; end
        else    begin s32 = 1'b1; op32 = o; a32 = av; b32 = bv; end
        @(negedge clk);
        s32 = 1'b0; s8 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1;
        check_eq({tag, ".busy1"}, 64'(w8 ? busy8 : busy32), 64'd1);
        check_eq({tag, ".dz_accept"}, 64'(w8 ? dz8 : dz32), 64'd0);
        while (!(w8 ? done8 : done32) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".hi"}, w8 ? 64'(hi8) : 64'(hi32), 64'(exp_hi));
        check_eq({tag, ".lo"}, w8 ? 64'(lo8) : 64'(lo32), 64'(exp_lo));
        check_eq({tag, ".dz"}, 64'(w8 ? dz8 : dz32), 64'(exp_dz));
        @(negedge clk);
        check_eq({tag, ".idle"}, 64'(w8 ? busy8 : busy32), 64'd0);
    endtask

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence
    initial begin
        int n;
        int pulses;
        reset = 1'b0;
        s32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        s8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.busy", 64'(busy32), 64'd0);
        check_eq("rst.done", 64'(done32), 64'd0);
        check_eq("rst.hi",   64'(hi32),   64'd0);
        check_eq("rst.lo",   64'(lo32),   64'd0);
        check_eq("rst.dz",   64'(dz32),   64'd0);
        reset = 1'b1;

        run_chk("mult_m1x2",  1'b0, OP_MULT,  32'hFFFFFFFF, 32'h2, 35, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_chk("multu_x2",   1'b0, OP_MULTU, 32'hFFFFFFFF, 32'h2, 35, 32'h1,        32'hFFFFFFFE, 1'b0);
        run_chk("divu_100_7", 1'b0, OP_DIVU,  32'd100,      32'd7, 35, 32'd2,        32'd14,       1'b0);
        run_chk("div_m7_2",   1'b0, OP_DIV,   32'hFFFFFFF9, 32'h2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_chk("div_min_m1", 1'b0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 35, 32'h0, 32'h80000000, 1'b0);
        run_chk("divu_pre",   1'b0, OP_DIVU,  32'h0ACF1234, 32'h2000, 35, 32'h1234, 32'h5678, 1'b0);
        run_chk("divu_zero",  1'b0, OP_DIVU,  32'd7,        32'd0, 2,  32'h1234,     32'h5678,     1'b1);
        check_eq("divu_zero.held", 64'(dz32), 64'd1);
        run_chk("multu_3x4",  1'b0, OP_MULTU, 32'd3,        32'd4, 35, 32'd0,        32'd12,       1'b0);

        // Start pulse while busy must be ignored; start on the done cycle too
        @(negedge clk);
        s32 = 1'b1; op32 = OP_MULTU; a32 = 32'd5; b32 = 32'd6;
        @(negedge clk);
        s32 = 1'b0;
        n = 1;
        while (!done32 && n < 200) begin
            if (n == 10) begin
                s32 = 1'b1; op32 = OP_MULT; a32 = 32'd100; b32 = 32'd100;
            end else begin
                s32 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check_eq("busy_pulse.latency", 64'(n), 64'd35);
        check_eq("busy_pulse.lo", 64'(lo32), 64'd30);
        check_eq("busy_pulse.hi", 64'(hi32), 64'd0);
        s32 = 1'b1; op32 = OP_MULTU; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        s32 = 1'b0;
        check_eq("done_start.idle", 64'(busy32), 64'd0);

        // Reset in the middle of a second operation abandons it
        @(negedge clk);
        s32 = 1'b1; op32 = OP_MULTU; a32 = 32'd7; b32 = 32'd9;
        @(negedge clk);
        s32 = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst.busy", 64'(busy32), 64'd0);
        check_eq("midrst.done", 64'(done32), 64'd0);
        check_eq("midrst.hi",   64'(hi32),   64'd0);
        check_eq("midrst.lo",   64'(lo32),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done32) pulses++;
        end
        check_eq("midrst.no_done", 64'(pulses), 64'd0);
        check_eq("midrst.lo_after", 64'(lo32), 64'd0);

        // Narrow instance: exact MIN*MIN product and signed truncating divide
        run_chk("w8_minmin", 1'b1, OP_MULT, 32'h80, 32'h80, 11, 32'h40, 32'h00, 1'b0);
        run_chk("w8_div",    1'b1, OP_DIV,  32'h85, 32'h0A, 11, 32'hFD, 32'hF4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
